operand_bypass_net: RTL and testbench

Parametrised operand bypass network for the in-order integer pipeline. It tracks every in-flight GPR write from EX to the final write-back stage in a per-stage scoreboard and forwards the youngest matching result to each decode read port. When the youngest producer has not yet computed its data (load-use or multi-cycle result), it raises a decode stall. It generalises the fixed-size RS/RT forwarding muxes: any stage count, any read-port count, plus an internal hazard scoreboard.

---
 rtl/operand_bypass_net.sv | 117 +++++++++++
 tb/tb_operand_bypass_net.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bypass_net.sv
// operand_bypass_net: per-stage write scoreboard plus youngest-producer operand
// forwarding for NRD decode read ports, with a decode stall when the youngest
// producer of an operand has not yet produced its result.
// Optional build macro: BYPASS_PERF_EN adds saturating stall/forward counters.
module operand_bypass_net #(
  parameter int NSTAGE = 3,
  parameter int NRD    = 2,
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int LW     = 2,
  parameter int SW     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic [AW-1:0]       issue_waddr,
  input  logic [LW-1:0]       issue_lat,
  input  logic                flush,
  input  logic [NSTAGE*DW-1:0] stage_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD*DW-1:0]   rd_gpr,
  output logic [NRD*DW-1:0]   rd_data,
  output logic [NRD*SW-1:0]   rd_sel,
  output logic                stall
`ifdef BYPASS_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_fwd_cnt
`endif
);

  // One in-flight GPR write: valid, destination, first stage holding its result.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] waddr;
    logic [LW-1:0] lat;
  } rec_t;

  rec_t sb [NSTAGE];

  logic          hit;
  int            hit_k;
  logic [AW-1:0] addr_p;
`ifdef BYPASS_PERF_EN
  logic          fwd_any;
`endif

  // Scoreboard shift: stage 0 takes the issuing write (or a bubble), older records move down.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the shift order is irrelevant.
    if (!rst_n || flush) begin
      // NOTE: only the valid bits are cleared; waddr/lat of an invalid record
      // are never looked at, so they need no reset.
      for (int k = 0; k < NSTAGE; k++) sb[k].v <= 1'b0;
    end else begin
      sb[0].v     <= issue_valid & ~stall & issue_we;
      sb[0].waddr <= issue_waddr;
      sb[0].lat   <= issue_lat;
      for (int k = 1; k < NSTAGE; k++) sb[k] <= sb[k-1];
    end
  end

  // Per-port youngest-match search, operand mux and readiness/stall generation.
  always_comb begin
    // NOTE: every combinationally driven signal gets a default before any
    // conditional assignment so no path can leave it holding a value (latch).
    stall   = 1'b0;
    rd_data = rd_gpr;
    rd_sel  = '0;
    hit     = 1'b0;
    hit_k   = 0;
    addr_p  = '0;
`ifdef BYPASS_PERF_EN
    fwd_any = 1'b0;
`endif
    for (int p = 0; p < NRD; p++) begin
      addr_p = rd_addr[p*AW +: AW];
      hit    = 1'b0;
      hit_k  = 0;
      // Scan oldest to youngest so the lowest matching stage is the one kept.
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (sb[k].v && sb[k].waddr == addr_p && addr_p != '0) begin
          hit   = 1'b1;
          hit_k = k;
        end
      end
      if (hit) begin
        rd_sel[p*SW +: SW] = SW'(hit_k + 1);
        if (int'(sb[hit_k].lat) > hit_k) begin
          // Producer has not reached the stage where its result exists yet.
          stall = 1'b1;
        end else begin
          rd_data[p*DW +: DW] = stage_data[hit_k*DW +: DW];
`ifdef BYPASS_PERF_EN
          fwd_any = 1'b1;
`endif
        end
      end
    end
  end

`ifdef BYPASS_PERF_EN
  // Saturating performance counters: stall cycles and cycles with a ready forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (fwd_any && perf_fwd_cnt != '1) perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_bypass_net.sv
// tb_operand_bypass_net: directed vectors for operand_bypass_net in its default
// configuration (NSTAGE=3, NRD=2, DW=32, AW=5). Perf counter checks are built
// only when BYPASS_PERF_EN is defined.
module tb_operand_bypass_net;

  localparam int NSTAGE = 3;
  localparam int NRD    = 2;
  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int LW     = 2;
  localparam int SW     = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 issue_valid;
  logic                 issue_we;
  logic [AW-1:0]        issue_waddr;
  logic [LW-1:0]        issue_lat;
  logic                 flush;
  logic [NSTAGE*DW-1:0] stage_data;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*DW-1:0]    rd_gpr;
  logic [NRD*DW-1:0]    rd_data;
  logic [NRD*SW-1:0]    rd_sel;
  logic                 stall;
`ifdef BYPASS_PERF_EN
  logic [31:0]          perf_stall_cnt;
  logic [31:0]          perf_fwd_cnt;
`endif

  int errors = 0;
  int checks = 0;

  operand_bypass_net #(
    .NSTAGE(NSTAGE), .NRD(NRD), .DW(DW), .AW(AW), .LW(LW), .SW(SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_waddr (issue_waddr),
    .issue_lat   (issue_lat),
    .flush       (flush),
    .stage_data  (stage_data),
    .rd_addr     (rd_addr),
    .rd_gpr      (rd_gpr),
    .rd_data     (rd_data),
    .rd_sel      (rd_sel),
    .stall       (stall)
`ifdef BYPASS_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Illegal latency must never be issued by this bench.
  always @(posedge clk) begin
    if (rst_n && issue_valid && issue_we)
      assert (int'(issue_lat) < NSTAGE) else $error("illegal issue_lat %0d", issue_lat);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] wa, input logic [LW-1:0] lat);
    issue_valid = 1'b1;
    issue_we    = we;
    issue_waddr = wa;
    issue_lat   = lat;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    issue_waddr = '0;
    issue_lat   = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] g);
    rd_addr[p*AW +: AW] = a;
    rd_gpr[p*DW +: DW]  = g;
  endtask

  task automatic set_sd(input int k, input logic [DW-1:0] d);
    stage_data[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    idle();
    flush = 1'b0;
    rd_addr = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    stage_data = '0;
    rd_addr    = '0;
    rd_gpr     = '0;
    idle();

    // Reset state
    set_rd(0, 5'd4, 32'hA5A5A5A5);
    step();
    rst_n = 1'b1;
    settle();
    check("reset_data0", rd_data[31:0], 32'hA5A5A5A5);
    check("reset_sel0",  32'(rd_sel[1:0]), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);

    // ALU forward: r5 lat 0, read next cycle from stage 0
    do_reset();
    issue(1'b1, 5'd5, 2'd0);
    step();
    idle();
    set_sd(0, 32'h00001234);
    set_rd(0, 5'd5, 32'h0BAD0BAD);
    settle();
    check("alu_data0",  rd_data[31:0], 32'h00001234);
    check("alu_sel0",   32'(rd_sel[1:0]), 32'd1);
    check("alu_stall",  32'(stall), 32'd0);

    // Load-use: r7 lat 2, consumer (writes r8, lat 0) stalls for two cycles
    do_reset();
    set_sd(0, 32'h00000000);
    set_sd(1, 32'h11111111);
    set_sd(2, 32'hDEADBEEF);
    issue(1'b1, 5'd7, 2'd2);
    step();
    issue(1'b1, 5'd8, 2'd0);
    set_rd(0, 5'd7, 32'hCAFEF00D);
    set_rd(1, 5'd8, 32'h88888888);
    settle();
    check("lu_c1_stall", 32'(stall), 32'd1);
    check("lu_c1_sel0",  32'(rd_sel[1:0]), 32'd1);
    step();
    check("lu_c2_stall",  32'(stall), 32'd1);
    check("lu_c2_sel0",   32'(rd_sel[1:0]), 32'd2);
    check("lu_c2_bubble", 32'(rd_sel[3:2]), 32'd0);
    step();
    check("lu_c3_stall", 32'(stall), 32'd0);
    check("lu_c3_sel0",  32'(rd_sel[1:0]), 32'd3);
    check("lu_c3_data0", rd_data[31:0], 32'hDEADBEEF);
    check("lu_c3_bubble", 32'(rd_sel[3:2]), 32'd0);
    step();
    idle();
    set_rd(0, 5'd0, 32'h0);
    set_sd(0, 32'h00000808);
    settle();
    check("lu_consumer_sel1",  32'(rd_sel[3:2]), 32'd1);
    check("lu_consumer_data1", rd_data[63:32], 32'h00000808);
`ifdef BYPASS_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, 32'd2);
    check("perf_fwd_cnt",   perf_fwd_cnt,   32'd1);
`endif
    set_rd(1, 5'd0, 32'h0);

    // Priority: two writes to r3, youngest (stage 0) wins
    do_reset();
    issue(1'b1, 5'd3, 2'd0);
    step();
    issue(1'b1, 5'd3, 2'd0);
    step();
    idle();
    set_sd(0, 32'h00000022);
    set_sd(1, 32'h00000011);
    set_rd(0, 5'd3, 32'h33333333);
    settle();
    check("prio_data0", rd_data[31:0], 32'h00000022);
    check("prio_sel0",  32'(rd_sel[1:0]), 32'd1);

    // Write to r0 never forwards
    do_reset();
    issue(1'b1, 5'd0, 2'd2);
    step();
    idle();
    set_rd(0, 5'd0, 32'h55555555);
    settle();
    check("r0_sel0",  32'(rd_sel[1:0]), 32'd0);
    check("r0_data0", rd_data[31:0], 32'h55555555);
    check("r0_stall", 32'(stall), 32'd0);

    // issue_we=0 occupies a slot but never matches
    do_reset();
    issue(1'b0, 5'd6, 2'd2);
    step();
    idle();
    set_rd(0, 5'd6, 32'h66666666);
    settle();
    check("nowe_sel0",  32'(rd_sel[1:0]), 32'd0);
    check("nowe_stall", 32'(stall), 32'd0);

    // Flush: kills r9 and ignores the r10 issued in the flush cycle
    do_reset();
    set_rd(0, 5'd0, 32'h0);
    issue(1'b1, 5'd9, 2'd2);
    step();
    issue(1'b1, 5'd10, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    set_rd(0, 5'd9,  32'h99999999);
    set_rd(1, 5'd10, 32'hAAAAAAAA);
    settle();
    check("flush_sel0",  32'(rd_sel[1:0]), 32'd0);
    check("flush_data0", rd_data[31:0], 32'h99999999);
    check("flush_sel1",  32'(rd_sel[3:2]), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    set_rd(1, 5'd0, 32'h0);

    // Reset mid-operation discards in-flight records
    do_reset();
    issue(1'b1, 5'd11, 2'd1);
    step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_rd(0, 5'd11, 32'hBBBBBBBB);
    settle();
    check("midrst_sel0",  32'(rd_sel[1:0]), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_data0", rd_data[31:0], 32'hBBBBBBBB);
`ifdef BYPASS_PERF_EN
    check("midrst_perf_stall", perf_stall_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
